// File: rtl/ttm4_prog_loader.sv
// ttm4_prog_loader: boot-time firmware loader for the TTM4 program memory.
// Receives a count byte followed by high/low byte pairs, writes each 15-bit
// word over the shared PA/IO/nWE bus, then releases the bus and lets the core run.
module ttm4_prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int WORD_W    = 15,
   parameter int WE_CYCLES = 1,
   parameter int TIMEOUT   = 50000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic              RX_READY,
   output logic [ADDR_W-1:0] PA,
   output logic              PA_OE,
   output logic [WORD_W-1:0] IO_W,
   output logic              IO_OE,
   output logic              nWE,
   output logic              nOE,
   output logic              nPC_OPEN,
   output logic              CORE_RST,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   typedef enum logic [3:0] {
      S_IDLE, S_CNT, S_HI, S_LO, S_SETUP, S_WRITE, S_HOLD, S_RUN, S_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [8:0]          rem_q, rem_d;     // words still to write, 1..256
   logic [6:0]          hi_q, hi_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [15:0]         tmo_q, tmo_d;     // idle cycles while waiting for a stream byte
   logic [3:0]          we_q, we_d;       // cycles nWE has been low for the current word
   logic                rdy_q, oe_q, nwe_q, run_q, busy_q, err_q;
   logic                accept;

   assign accept   = RX_VALID & rdy_q;

   assign RX_READY = rdy_q;
   assign PA       = addr_q;
   assign PA_OE    = oe_q;
   assign IO_W     = word_q;
   assign IO_OE    = oe_q;
   assign nWE      = nwe_q;
   // The core only leaves reset and owns the bus once the loader is in RUN.
   assign nOE      = ~run_q;
   assign nPC_OPEN = ~run_q;
   assign CORE_RST = ~run_q;
   assign DONE     = run_q;
   assign BUSY     = busy_q;
   assign ERR      = err_q;

   // Next-state and datapath-next logic for the load sequencer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      word_d  = word_q;
      tmo_d   = tmo_q;
      we_d    = we_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_CNT;
               tmo_d   = '0;
            end
         end
         S_CNT: begin
            // No timeout here: the host may take as long as it likes to begin.
            if (accept) begin
               rem_d   = (RX_DATA == 8'd0) ? 9'd256 : {1'b0, RX_DATA};
               addr_d  = '0;
               tmo_d   = '0;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (accept) begin
               tmo_d = '0;
               if (RX_DATA[7]) begin
                  state_d = S_ERROR;
               end else begin
                  hi_d    = RX_DATA[6:0];
                  state_d = S_LO;
               end
            end else begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == 16'(TIMEOUT)) state_d = S_ERROR;
            end
         end
         S_LO: begin
            if (accept) begin
               tmo_d   = '0;
               word_d  = WORD_W'({hi_q, RX_DATA});
               state_d = S_SETUP;
            end else begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == 16'(TIMEOUT)) state_d = S_ERROR;
            end
         end
         S_SETUP: begin
            we_d    = '0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (we_q == 4'(WE_CYCLES - 1)) state_d = S_HOLD;
            else                           we_d    = we_q + 4'd1;
         end
         S_HOLD: begin
            // Address wraps naturally after 0xFF; a 256-word load ends here.
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 9'd1;
            state_d = (rem_q == 9'd1) ? S_RUN : S_HI;
         end
         S_RUN, S_ERROR: begin
            if (START) begin
               state_d = S_CNT;
               tmo_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and output registers; outputs decode the upcoming state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         word_q  <= '0;
         tmo_q   <= '0;
         we_q    <= '0;
         rdy_q   <= 1'b0;
         oe_q    <= 1'b0;
         nwe_q   <= 1'b1;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         word_q  <= word_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         rdy_q   <= (state_d == S_CNT) || (state_d == S_HI) || (state_d == S_LO);
         oe_q    <= (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
         nwe_q   <= (state_d != S_WRITE);
         run_q   <= (state_d == S_RUN);
         busy_q  <= (state_d == S_CNT) || (state_d == S_HI) || (state_d == S_LO) ||
                    (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
         err_q   <= (state_d == S_ERROR);
      end
   end

endmodule

// File: tb/tb_ttm4_prog_loader.sv
// Testbench for ttm4_prog_loader: directed and randomized load sessions on two
// instances (WE_CYCLES=1 and WE_CYCLES=3, both TIMEOUT=20) with a bus monitor.
module tb_ttm4_prog_loader;

   logic       clk = 1'b0;
   logic       rst, start, rx_valid, sel;
   logic [7:0] rx_data;

   always #5 clk = ~clk;

   logic        a_rdy, a_pa_oe, a_io_oe, a_nwe, a_noe, a_npc, a_crst, a_busy, a_done, a_err;
   logic [7:0]  a_pa;
   logic [14:0] a_io;
   logic        b_rdy, b_pa_oe, b_io_oe, b_nwe, b_noe, b_npc, b_crst, b_busy, b_done, b_err;
   logic [7:0]  b_pa;
   logic [14:0] b_io;

   ttm4_prog_loader #(.ADDR_W(8), .WORD_W(15), .WE_CYCLES(1), .TIMEOUT(20)) dut_a (
      .CLK(clk), .RST(rst), .START(start & ~sel), .RX_DATA(rx_data),
      .RX_VALID(rx_valid & ~sel), .RX_READY(a_rdy), .PA(a_pa), .PA_OE(a_pa_oe),
      .IO_W(a_io), .IO_OE(a_io_oe), .nWE(a_nwe), .nOE(a_noe), .nPC_OPEN(a_npc),
      .CORE_RST(a_crst), .BUSY(a_busy), .DONE(a_done), .ERR(a_err));

   ttm4_prog_loader #(.ADDR_W(8), .WORD_W(15), .WE_CYCLES(3), .TIMEOUT(20)) dut_b (
      .CLK(clk), .RST(rst), .START(start & sel), .RX_DATA(rx_data),
      .RX_VALID(rx_valid & sel), .RX_READY(b_rdy), .PA(b_pa), .PA_OE(b_pa_oe),
      .IO_W(b_io), .IO_OE(b_io_oe), .nWE(b_nwe), .nOE(b_noe), .nPC_OPEN(b_npc),
      .CORE_RST(b_crst), .BUSY(b_busy), .DONE(b_done), .ERR(b_err));

   logic        cur_rdy, cur_pa_oe, cur_io_oe, cur_nwe, cur_noe, cur_npc, cur_crst, cur_busy, cur_done, cur_err;
   logic [7:0]  cur_pa;
   logic [14:0] cur_io;
   assign cur_rdy   = sel ? b_rdy   : a_rdy;
   assign cur_pa_oe = sel ? b_pa_oe : a_pa_oe;
   assign cur_io_oe = sel ? b_io_oe : a_io_oe;
   assign cur_nwe   = sel ? b_nwe   : a_nwe;
   assign cur_noe   = sel ? b_noe   : a_noe;
   assign cur_npc   = sel ? b_npc   : a_npc;
   assign cur_crst  = sel ? b_crst  : a_crst;
   assign cur_busy  = sel ? b_busy  : a_busy;
   assign cur_done  = sel ? b_done  : a_done;
   assign cur_err   = sel ? b_err   : a_err;
   assign cur_pa    = sel ? b_pa    : a_pa;
   assign cur_io    = sel ? b_io    : a_io;

   // ---------------- bus monitor: records every nWE pulse ----------------
   typedef struct packed {
      logic [7:0]  pa;
      logic [14:0] io;
      logic [7:0]  len;
   } wr_t;

   wr_t         wlog[$];
   int          cyc = 0;
   int          low_len = 0, viol = 0, unstable = 0, rdy_viol = 0;
   logic        oe_prev = 1'b0;
   logic [7:0]  cap_pa = '0, wpa = '0;
   logic [14:0] cap_io = '0, wio = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cur_nwe === 1'b0) begin
         if (!(cur_pa_oe && cur_io_oe)) viol++;
         if (low_len == 0) begin
            wpa = cur_pa;
            wio = cur_io;
         end
         low_len++;
      end else if (low_len != 0) begin
         wlog.push_back('{pa: wpa, io: wio, len: 8'(low_len)});
         low_len = 0;
      end
      if (cur_pa_oe === 1'b1) begin
         if (!oe_prev) begin
            cap_pa = cur_pa;
            cap_io = cur_io;
         end else if (cur_pa !== cap_pa || cur_io !== cap_io) begin
            unstable++;
         end
         if (cur_rdy === 1'b1) rdy_viol++;
      end
      oe_prev = cur_pa_oe;
   end

   // ---------------- checking helpers ----------------
   int          vectors = 0, miscompares = 0;
   logic [7:0]  bq[$];     // byte stream to send
   logic [14:0] expw[$];   // reference model: words expected at addresses 0,1,2...

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"},   32'(cur_rdy),   32'd0);
      chk({tag, "_pa"},    32'(cur_pa),    32'd0);
      chk({tag, "_pa_oe"}, 32'(cur_pa_oe), 32'd0);
      chk({tag, "_io"},    32'(cur_io),    32'd0);
      chk({tag, "_io_oe"}, 32'(cur_io_oe), 32'd0);
      chk({tag, "_nwe"},   32'(cur_nwe),   32'd1);
      chk({tag, "_noe"},   32'(cur_noe),   32'd1);
      chk({tag, "_npc"},   32'(cur_npc),   32'd1);
      chk({tag, "_crst"},  32'(cur_crst),  32'd1);
      chk({tag, "_busy"},  32'(cur_busy),  32'd0);
      chk({tag, "_done"},  32'(cur_done),  32'd0);
      chk({tag, "_err"},   32'(cur_err),   32'd0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Hold RX_VALID until the loader takes the byte (bounded), after gap idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r, ok;
      ok = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         r = cur_rdy;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      chk("rx_accept", 32'(ok), 32'd1);
   endtask

   task automatic send_stream(input int gap_max);
      for (int i = 0; i < bq.size(); i++)
         send_byte(bq[i], (gap_max < 0) ? 6 : $urandom_range(gap_max, 0));
   endtask

   // Build a random N-word load: count byte plus high/low pairs, and the expected words.
   task automatic make_random(input int n);
      logic [14:0] w;
      bq.delete();
      expw.delete();
      bq.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         w = 15'($urandom);
         expw.push_back(w);
         bq.push_back({1'b0, w[14:8]});
         bq.push_back(w[7:0]);
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 5000; k++) begin
         if (cur_done === 1'b1) break;
         @(negedge clk);
      end
      chk("done_wait", 32'(cur_done), 32'd1);
   endtask

   task automatic check_writes(input string tag, input int base, input int n, input int we);
      chk({tag, "_wr_count"}, 32'(wlog.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (base + i < wlog.size()) begin
            chk({tag, "_wr_pa"},  32'(wlog[base+i].pa),  32'(i % 256));
            chk({tag, "_wr_io"},  32'(wlog[base+i].io),  32'(expw[i]));
            chk({tag, "_wr_len"}, 32'(wlog[base+i].len), 32'(we));
         end
      end
   endtask

   task automatic chk_run(input string tag);
      chk({tag, "_done"},  32'(cur_done),  32'd1);
      chk({tag, "_npc"},   32'(cur_npc),   32'd0);
      chk({tag, "_noe"},   32'(cur_noe),   32'd0);
      chk({tag, "_crst"},  32'(cur_crst),  32'd0);
      chk({tag, "_pa_oe"}, 32'(cur_pa_oe), 32'd0);
      chk({tag, "_io_oe"}, 32'(cur_io_oe), 32'd0);
      chk({tag, "_busy"},  32'(cur_busy),  32'd0);
      chk({tag, "_err"},   32'(cur_err),   32'd0);
   endtask

   logic [7:0]  t1_bytes[11] = '{8'h05, 8'h00, 8'h00, 8'h05, 8'h02, 8'h51, 8'h23, 8'h07, 8'h84, 8'h30, 8'h00};
   logic [14:0] t1_words[5]  = '{15'h0000, 15'h0502, 15'h5123, 15'h0784, 15'h3000};
   int          base, c0, c1;
   logic [14:0] w1, w2;

   initial begin
      rst = 1'b1; start = 1'b0; rx_data = '0; rx_valid = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst_a");
      sel = 1'b1;
      #1 chk_reset("rst_b");
      sel = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // RX_VALID in IDLE is not consumed
      rx_data = 8'h55; rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_rdy",  32'(cur_rdy),  32'd0);
      chk("idle_busy", 32'(cur_busy), 32'd0);
      rx_valid = 1'b0;

      // Five-word load, back-to-back bytes
      base = wlog.size();
      start_pulse();
      c0 = cyc;
      chk("t1_busy", 32'(cur_busy), 32'd1);
      chk("t1_rdy",  32'(cur_rdy),  32'd1);
      bq.delete(); expw.delete();
      foreach (t1_bytes[i]) bq.push_back(t1_bytes[i]);
      foreach (t1_words[i]) expw.push_back(t1_words[i]);
      send_stream(0);
      wait_done();
      c1 = cyc;
      chk("t1_latency", 32'(c1 - c0), 32'(1 + 5 * (2 + 2 + 1)));
      check_writes("t1", base, 5, 1);
      chk_run("t1_run");

      // Throttled source, restart from RUN
      start_pulse();
      chk("t2_noe",  32'(cur_noe),  32'd1);
      chk("t2_npc",  32'(cur_npc),  32'd1);
      chk("t2_crst", 32'(cur_crst), 32'd1);
      chk("t2_done", 32'(cur_done), 32'd0);
      chk("t2_busy", 32'(cur_busy), 32'd1);
      make_random(3);
      base = wlog.size();
      send_stream(-1);
      wait_done();
      check_writes("t2", base, 3, 1);
      chk("t2_err", 32'(cur_err), 32'd0);

      // Randomized loads with random gaps; first one gets a stray START mid-load
      for (int it = 0; it < 3; it++) begin
         make_random($urandom_range(8, 1));
         base = wlog.size();
         start_pulse();
         send_byte(bq[0], 0);
         if (it == 0) start_pulse();
         bq.pop_front();
         send_stream(3);
         wait_done();
         check_writes("rnd", base, expw.size(), 1);
         chk("rnd_err", 32'(cur_err), 32'd0);
      end

      // Illegal high byte in word 2
      w1 = 15'($urandom);
      expw.delete(); expw.push_back(w1);
      base = wlog.size();
      start_pulse();
      send_byte(8'h03, 0);
      send_byte({1'b0, w1[14:8]}, 0);
      send_byte(w1[7:0], 0);
      send_byte(8'h85, 0);
      chk("t3_err",  32'(cur_err),  32'd1);
      chk("t3_busy", 32'(cur_busy), 32'd0);
      chk("t3_npc",  32'(cur_npc),  32'd1);
      chk("t3_crst", 32'(cur_crst), 32'd1);
      chk("t3_rdy",  32'(cur_rdy),  32'd0);
      check_writes("t3", base, 1, 1);
      rx_data = 8'h11; rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("t3_err_rdy", 32'(cur_rdy), 32'd0);
      rx_valid = 1'b0;
      start_pulse();
      chk("t3_recover_err",  32'(cur_err),  32'd0);
      chk("t3_recover_busy", 32'(cur_busy), 32'd1);
      chk("t3_recover_rdy",  32'(cur_rdy),  32'd1);

      // No timeout while waiting for the count byte
      repeat (30) @(negedge clk);
      chk("t4_cnt_no_tmo", 32'(cur_err), 32'd0);

      // Timeout after one of two words: 3 bus cycles then 20 idle cycles in HI
      w2 = 15'($urandom);
      expw.delete(); expw.push_back(w2);
      base = wlog.size();
      send_byte(8'h02, 0);
      send_byte({1'b0, w2[14:8]}, 0);
      send_byte(w2[7:0], 0);
      repeat (3 + 20 - 1) @(negedge clk);
      chk("t4_err_before", 32'(cur_err), 32'd0);
      @(negedge clk);
      chk("t4_err_at", 32'(cur_err), 32'd1);
      chk("t4_npc",    32'(cur_npc), 32'd1);
      check_writes("t4", base, 1, 1);

      // 256-word load on the WE_CYCLES=3 instance, word = address
      sel = 1'b1;
      @(negedge clk);
      bq.delete(); expw.delete();
      bq.push_back(8'h00);
      for (int i = 0; i < 256; i++) begin
         expw.push_back(15'(i));
         bq.push_back(8'h00);
         bq.push_back(8'(i));
      end
      base = wlog.size();
      start_pulse();
      c0 = cyc;
      send_stream(0);
      wait_done();
      c1 = cyc;
      chk("t5_latency", 32'(c1 - c0), 32'(1 + 256 * (2 + 2 + 3)));
      check_writes("t5", base, 256, 3);
      if (wlog.size() > 0) chk("t5_last_pa", 32'(wlog[wlog.size()-1].pa), 32'hFF);
      chk_run("t5_run");
      sel = 1'b0;
      @(negedge clk);

      // Reset during the write of word 3
      make_random(5);
      base = wlog.size();
      start_pulse();
      for (int i = 0; i < 7; i++) send_byte(bq[i], 0);
      @(negedge clk);
      chk("t6_nwe_low",  32'(cur_nwe),   32'd0);
      chk("t6_pa_oe",    32'(cur_pa_oe), 32'd1);
      chk("t6_pa",       32'(cur_pa),    32'd2);
      #2 rst = 1'b1;
      #1 chk_reset("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      chk("t6_wr_min", 32'(wlog.size() - base >= 2), 32'd1);
      if (wlog.size() - base >= 2) begin
         chk("t6_w0", 32'(wlog[base].io),   32'(expw[0]));
         chk("t6_w1", 32'(wlog[base+1].io), 32'(expw[1]));
      end
      @(negedge clk);
      chk("t6_idle_busy", 32'(cur_busy), 32'd0);
      chk("t6_idle_rdy",  32'(cur_rdy),  32'd0);

      // Whole-run bus rules
      chk("nwe_without_oe",   32'(viol),     32'd0);
      chk("bus_unstable",     32'(unstable), 32'd0);
      chk("rdy_during_write", 32'(rdy_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ttm4_prog_loader.md
Name: ttm4_prog_loader

Overview:
- Boot-time firmware loader that sits directly upstream of the TTM4 MEMORY block.
- Takes a byte stream from a serial receiver and assembles 15-bit instruction words.
- Writes each word into program memory through the shared PA/IO/nWE bus.
- When loading is complete, releases the bus and lets the program counter run by asserting nOE and nPC_OPEN low.
- Replaces the hand-sequenced firmware load used in simulation with synthesizable hardware.

Parameters:
- ADDR_W, 8, program address width (PA bus).
- WORD_W, 15, instruction width {OP[4:0], SR[2:0], LR[2:0], IM[3:0]}.
- WE_CYCLES, 1, number of cycles nWE is held low per word (1..15).
- TIMEOUT, 50000, idle cycles allowed between stream bytes before abort (16-bit counter).

Ports:
- CLK, input, 1: system clock (50 MHz).
- RST, input, 1: asynchronous, active-high reset.
- START, input, 1: single-cycle pulse that begins a load session.
- RX_DATA, input, 8: stream byte.
- RX_VALID, input, 1: RX_DATA is valid.
- RX_READY, output, 1: loader accepts a byte. A transfer occurs when RX_VALID and RX_READY are both high on a rising CLK edge.
- PA, output, ADDR_W: program address.
- PA_OE, output, 1: PA drive enable. The top level tri-states PA when this is low.
- IO_W, output, WORD_W: write data for IM/LR/SR/OP.
- IO_OE, output, 1: IO drive enable.
- nWE, output, 1: memory write strobe, active-low.
- nOE, output, 1: memory output enable, active-low.
- nPC_OPEN, output, 1: program-counter bus release, active-low.
- CORE_RST, output, 1: holds REGISTERS/PC in reset, active-high.
- BUSY, output, 1: a load session is in progress.
- DONE, output, 1: load completed; core is running.
- ERR, output, 1: load aborted.

Behaviour:
- Stream format: one count byte N (0 means 256 words), then N words. Each word is sent high byte first, then low byte. Word = {hi[6:0], lo[7:0]}. Bit 7 of every high byte must be 0.
- Reset values: RX_READY=0, PA=0, PA_OE=0, IO_W=0, IO_OE=0, nWE=1, nOE=1, nPC_OPEN=1, CORE_RST=1, BUSY=0, DONE=0, ERR=0. State=IDLE.
- States:
  - IDLE: no bus drive. START -> CNT.
  - CNT: RX_READY=1, BUSY=1. Byte accepted -> remaining=N (0 -> 256), addr=0, go to HI.
  - HI: RX_READY=1. Byte with bit7=1 -> ERROR. Otherwise latch it and go to LO.
  - LO: RX_READY=1. Latch byte -> SETUP. RX_READY drops in the same cycle the LO byte is accepted.
  - SETUP: 1 cycle. PA_OE=1, IO_OE=1, PA=addr, IO_W=word, nWE=1.
  - WRITE: WE_CYCLES cycles with nWE=0. PA and IO_W are held stable.
  - HOLD: 1 cycle, nWE=1, PA and IO_W still driven. Then addr increments and remaining decrements. If remaining is now 0 -> RUN, else -> HI.
  - RUN: PA_OE=0, IO_OE=0, CORE_RST=0, nOE=0, nPC_OPEN=0, DONE=1, BUSY=0. START -> CNT with nOE=1, nPC_OPEN=1, CORE_RST=1, DONE=0 in the same edge.
  - ERROR: all bus drives off, nWE=1, nOE=1, nPC_OPEN=1, CORE_RST=1, ERR=1, BUSY=0. START -> CNT and clears ERR.
- CORE_RST=1 in every state except RUN.
- nWE is never low while PA_OE=0 or IO_OE=0.
- Per-word cost with back-to-back bytes: 2 accept cycles + 2 + WE_CYCLES bus cycles.
- Timeout: the counter clears on every accepted byte and on entry to CNT. It counts only in HI and LO. Reaching TIMEOUT -> ERROR. No timeout in CNT.
- Address wrap: addr is ADDR_W bits. With N=0 (256 words), words go to 0x00..0xFF; addr wraps to 0 and the loader enters RUN. No extra write occurs.
- START while BUSY (CNT..HOLD) is ignored.
- RX_VALID outside CNT/HI/LO is not consumed (RX_READY=0).
- RST asserted mid-write: nWE returns to 1 and bus drives go off immediately (asynchronous). Memory contents already written are not cleared.

Test Plan:
- Load 5 words. Stream 05 00 00 05 02 51 23 07 84 30 00 -> writes PA 0..4 = 0x0000, 0x0502, 0x5123, 0x0784, 0x3000. Each nWE low for exactly 1 cycle with PA/IO stable from SETUP through HOLD. Then DONE=1, nPC_OPEN=0, nOE=0, CORE_RST=0, PA_OE=0.
- Throttled source (RX_VALID asserted every 7th cycle, 3 words) -> identical memory contents; no ERR; RX_READY low during SETUP/WRITE/HOLD.
- High byte 0x85 in word 2 -> ERROR next cycle, ERR=1, only word 1 written, nPC_OPEN stays 1. START then recovers to CNT with ERR=0.
- Count 0x02, one word sent, then TIMEOUT=20 idle cycles -> ERR=1 on cycle 20, nWE never pulses for word 2.
- Count 0x00 with 256 words (word = address) -> 256 writes to 0x00..0xFF, final PA=0xFF, then RUN. Bench also checks WE_CYCLES=3 gives 3-cycle nWE pulses.
- RST pulsed during WRITE of word 3 -> all outputs at reset values within the same cycle, state IDLE, BUSY=0.
